// File: rtl/clock_step_controller.sv
// CPU clock-enable generator: free-running (RUN) or single-step (STEP) ticks from a programmable divider.
// Optional feature: define TICK_COUNT_EN to enable the wrapping 16-bit tick_count register.
module clock_step_controller #(
    parameter logic [15:0] DIV_SLOW = 16'd2500,
    parameter logic [15:0] DIV_FAST = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_freq,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        halt,
    output logic        cpu_tick,
    output logic        step_done,
    output logic        busy,
    output logic [1:0]  state,
    output logic [15:0] tick_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t      cur;
    logic [15:0] count;
    logic [15:0] div_sel;
    logic        at_term;
    logic        tick_fire;

    // Divisor is re-selected every cycle, so a frequency change applies mid-count.
    assign div_sel   = set_freq ? DIV_FAST : DIV_SLOW;
    assign at_term   = (count >= div_sel);
    assign tick_fire = at_term && (((cur == RUN) && run_req && !halt) || (cur == STEP));

    assign state = cur;
    assign busy  = (cur == RUN) || (cur == STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= IDLE;
            count     <= 16'd0;
            cpu_tick  <= 1'b0;
            step_done <= 1'b0;
        end else begin
            cpu_tick  <= 1'b0;
            step_done <= 1'b0;
            case (cur)
                IDLE: begin
                    count <= 16'd0;
                    if (run_req)       cur <= RUN;
                    else if (step_req) cur <= STEP;
                end
                RUN: begin
                    if (!run_req) begin
                        cur   <= IDLE;
                        count <= 16'd0;
                    end else if (halt) begin
                        cur   <= HALTED;
                        count <= 16'd0;
                    end else if (tick_fire) begin
                        cpu_tick <= 1'b1;
                        count    <= 16'd0;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                // A step always completes; run_req, step_req and halt are ignored here.
                STEP: begin
                    if (tick_fire) begin
                        cpu_tick  <= 1'b1;
                        step_done <= 1'b1;
                        count     <= 16'd0;
                        cur       <= IDLE;
                    end else begin
                        count <= count + 16'd1;
                    end
                end
                HALTED: begin
                    count <= 16'd0;
                    if (!run_req) cur <= IDLE;
                end
                default: begin
                    cur   <= IDLE;
                    count <= 16'd0;
                end
            endcase
        end
    end

`ifdef TICK_COUNT_EN
    logic [15:0] tick_q;

    // Counts on the same edge that raises cpu_tick, so it already includes the visible tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         tick_q <= 16'd0;
        else if (tick_fire) tick_q <= tick_q + 16'd1;
    end

    assign tick_count = tick_q;
`else
    assign tick_count = 16'd0;
`endif

endmodule

// File: tb/tb_clock_step_controller.sv
// Scoreboard bench for clock_step_controller: stimulus pushes expected ticks (cycle, step_done, tick_count),
// a negedge monitor pops one entry per observed cpu_tick. Two instances cover the (4,0) and (10,2) dividers.
module tb_clock_step_controller;

    localparam int W = 49;

    logic clk = 1'b0;
    logic reset;

    logic        set_freq, run_req, step_req, halt;
    logic        a_tick, a_done, a_busy;
    logic [1:0]  a_state;
    logic [15:0] a_tc;

    logic        b_set_freq, b_run, b_step, b_halt;
    logic        b_tick, b_done, b_busy;
    logic [1:0]  b_state;
    logic [15:0] b_tc;

    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [15:0]  a_tc_model = 16'd0;
    logic [15:0]  b_tc_model = 16'd0;

    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int unsigned base;

    clock_step_controller #(.DIV_SLOW(16'd4), .DIV_FAST(16'd0)) u_dut (
        .clk(clk), .reset(reset), .set_freq(set_freq), .run_req(run_req),
        .step_req(step_req), .halt(halt), .cpu_tick(a_tick), .step_done(a_done),
        .busy(a_busy), .state(a_state), .tick_count(a_tc)
    );

    clock_step_controller #(.DIV_SLOW(16'd10), .DIV_FAST(16'd2)) u_dut_b (
        .clk(clk), .reset(reset), .set_freq(b_set_freq), .run_req(b_run),
        .step_req(b_step), .halt(b_halt), .cpu_tick(b_tick), .step_done(b_done),
        .busy(b_busy), .state(b_state), .tick_count(b_tc)
    );

    // Clock / reset-independent cycle counter (value seen at negedge = posedges so far)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Driver tasks
    task automatic goto(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int unsigned at, input logic step);
        a_tc_model = a_tc_model + 16'd1;
`ifdef TICK_COUNT_EN
        exp_a_q.push_back({at, step, a_tc_model});
`else
        exp_a_q.push_back({at, step, 16'd0});
`endif
    endtask

    task automatic push_b(input int unsigned at, input logic step);
        b_tc_model = b_tc_model + 16'd1;
`ifdef TICK_COUNT_EN
        exp_b_q.push_back({at, step, b_tc_model});
`else
        exp_b_q.push_back({at, step, 16'd0});
`endif
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (a_tick) begin
            n_cmp++;
            if (exp_a_q.size() == 0) begin
                n_bad++;
                $display("FAIL a_unexpected_tick: got tick at cyc %0d step_done=%0b, want no tick", cyc, a_done);
            end else begin
                e = exp_a_q.pop_front();
                if ({cyc, a_done, a_tc} !== e) begin
                    n_bad++;
                    $display("FAIL a_tick: got cyc=%0d done=%0b tc=%0d want cyc=%0d done=%0b tc=%0d",
                             cyc, a_done, a_tc, e[48:17], e[16], e[15:0]);
                end
            end
        end else if (a_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_stray_done: got step_done=1 without cpu_tick at cyc %0d, want 0", cyc);
        end
        if (b_tick) begin
            n_cmp++;
            if (exp_b_q.size() == 0) begin
                n_bad++;
                $display("FAIL b_unexpected_tick: got tick at cyc %0d, want no tick", cyc);
            end else begin
                e = exp_b_q.pop_front();
                if ({cyc, b_done, b_tc} !== e) begin
                    n_bad++;
                    $display("FAIL b_tick: got cyc=%0d done=%0b tc=%0d want cyc=%0d done=%0b tc=%0d",
                             cyc, b_done, b_tc, e[48:17], e[16], e[15:0]);
                end
            end
        end else if (b_done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_stray_done: got step_done=1 without cpu_tick at cyc %0d, want 0", cyc);
        end
    end

    initial begin
        reset = 1'b0;
        set_freq = 1'b0; run_req = 1'b0; step_req = 1'b0; halt = 1'b0;
        b_set_freq = 1'b0; b_run = 1'b0; b_step = 1'b0; b_halt = 1'b0;
        #1;
        check("rst_state", 32'(a_state), 32'd0);
        check("rst_tick", 32'(a_tick), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_tc", 32'(a_tc), 32'd0);
        goto(2);
        reset = 1'b1;
        goto(4);

        // Free run, DIV_SLOW=4: first tick 5 cycles after entering RUN, then every 5
        base = cyc;
        run_req = 1'b1;
        push_a(base + 6, 1'b0);
        push_a(base + 11, 1'b0);
        push_a(base + 16, 1'b0);
        goto(base + 1);
        check("run_state", 32'(a_state), 32'd1);
        check("run_busy", 32'(a_busy), 32'd1);
        goto(base + 18);
        run_req = 1'b0;
        goto(base + 19);
        check("run_stop_state", 32'(a_state), 32'd0);
        goto(base + 25);

        // Single step with DIV_FAST=0: tick + step_done on first STEP cycle
        set_freq = 1'b1;
        base = cyc;
        step_req = 1'b1;
        push_a(base + 2, 1'b1);
        goto(base + 1);
        step_req = 1'b0;
        check("step_state", 32'(a_state), 32'd2);
        check("step_busy", 32'(a_busy), 32'd1);
        goto(base + 2);
        check("step_back_idle", 32'(a_state), 32'd0);
        goto(base + 6);

        // Slow step: run_req pulse, step_req and halt during STEP must not disturb it
        set_freq = 1'b0;
        base = cyc;
        step_req = 1'b1;
        push_a(base + 6, 1'b1);
        goto(base + 1);
        step_req = 1'b0;
        goto(base + 2);
        run_req = 1'b1;
        step_req = 1'b1;
        goto(base + 3);
        run_req = 1'b0;
        step_req = 1'b0;
        halt = 1'b1;
        goto(base + 4);
        halt = 1'b0;
        check("step_ignores_inputs", 32'(a_state), 32'd2);
        goto(base + 6);
        check("slow_step_idle", 32'(a_state), 32'd0);
        goto(base + 10);

        // Halt at count 2: no ticks, HALTED survives halt release, run_req=0 -> IDLE
        base = cyc;
        run_req = 1'b1;
        goto(base + 3);
        halt = 1'b1;
        goto(base + 4);
        check("halt_state", 32'(a_state), 32'd3);
        check("halt_busy", 32'(a_busy), 32'd0);
        goto(base + 5);
        halt = 1'b0;
        goto(base + 12);
        check("halt_no_resume", 32'(a_state), 32'd3);
        run_req = 1'b0;
        goto(base + 13);
        check("halt_to_idle", 32'(a_state), 32'd0);

        // run_req and step_req together: RUN wins
        base = cyc;
        run_req = 1'b1;
        step_req = 1'b1;
        goto(base + 1);
        check("both_req_run", 32'(a_state), 32'd1);
        run_req = 1'b0;
        step_req = 1'b0;
        goto(base + 2);
        check("both_req_idle", 32'(a_state), 32'd0);
        goto(base + 4);

        // Async reset while cpu_tick is high (div_sel=0 in RUN ticks every cycle)
        set_freq = 1'b1;
        base = cyc;
        run_req = 1'b1;
        push_a(base + 2, 1'b0);
        push_a(base + 3, 1'b0);
        goto(base + 3);
        #2;
        reset = 1'b0;
        run_req = 1'b0;
        #1;
        check("async_rst_tick", 32'(a_tick), 32'd0);
        check("async_rst_state", 32'(a_state), 32'd0);
        check("async_rst_tc", 32'(a_tc), 32'd0);
        a_tc_model = 16'd0;
        b_tc_model = 16'd0;
        goto(base + 4);
        reset = 1'b1;
        goto(base + 6);

        // Reset mid-STEP at count 3: abort, no step_done, needs a fresh request
        set_freq = 1'b0;
        base = cyc;
        step_req = 1'b1;
        goto(base + 1);
        step_req = 1'b0;
        goto(base + 4);
        check("pre_rst_step", 32'(a_state), 32'd2);
        reset = 1'b0;
        #1;
        check("mid_step_rst_state", 32'(a_state), 32'd0);
        check("mid_step_rst_done", 32'(a_done), 32'd0);
        check("mid_step_rst_busy", 32'(a_busy), 32'd0);
        check("mid_step_rst_tc", 32'(a_tc), 32'd0);
        a_tc_model = 16'd0;
        b_tc_model = 16'd0;
        goto(base + 5);
        reset = 1'b1;
        goto(base + 12);
        check("after_rst_idle", 32'(a_state), 32'd0);

        // Instance B: DIV_SLOW=10 -> DIV_FAST=2 at count 7 ticks immediately, then every 3
        base = cyc;
        b_run = 1'b1;
        push_b(base + 9, 1'b0);
        push_b(base + 12, 1'b0);
        push_b(base + 15, 1'b0);
        goto(base + 1);
        check("b_run_state", 32'(b_state), 32'd1);
        goto(base + 8);
        b_set_freq = 1'b1;
        goto(base + 16);
        b_run = 1'b0;
        goto(base + 17);
        check("b_idle", 32'(b_state), 32'd0);
        goto(base + 22);

        // Long run at div_sel=0: 65537 back-to-back ticks, tick_count wraps to 1 when enabled
        set_freq = 1'b1;
        base = cyc;
        run_req = 1'b1;
        for (int i = 0; i < 65537; i++) push_a(base + 2 + i, 1'b0);
        goto(base + 65538);
        run_req = 1'b0;
        goto(base + 65539);
        check("long_run_idle", 32'(a_state), 32'd0);
`ifdef TICK_COUNT_EN
        check("tc_wrap", 32'(a_tc), 32'd1);
`else
        check("tc_wrap", 32'(a_tc), 32'd0);
`endif
        goto(base + 65545);

        check("a_queue_drained", 32'(exp_a_q.size()), 32'd0);
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
